// File: rtl/ps2_key_ctrl_pkg.sv
// Shared PS/2 key-sequencer types: prefix byte constants, FSM state and key identity.
package ps2_pkg;

    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        SETTLE
    } ctrl_state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_id_t;

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Handshake between the ps2_keyboard FIFO (master) and the key sequencer (slave).
interface ps2_key_ctrl_if;

    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;
    logic       kbd_nextdata_n;

    modport master (
        output kbd_data,
        output kbd_ready,
        output kbd_overflow,
        input  kbd_nextdata_n
    );

    modport slave (
        input  kbd_data,
        input  kbd_ready,
        input  kbd_overflow,
        output kbd_nextdata_n
    );

endinterface

// File: rtl/ps2_key_ctrl.sv
// Drains the PS/2 FIFO one byte per 3 cycles, decodes E0/F0 prefixes and tracks the held key.
// Optional macro PS2_REPEAT_EN adds a repeat_pulse output for typematic makes.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    ps2_key_ctrl_if.slave    kbd,
    input  logic             ovf_clr,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_valid,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             ovf_flag
`ifdef PS2_REPEAT_EN
    ,
    output logic             repeat_pulse
`endif
);

    ctrl_state_t      state_q, state_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       code_q, code_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    key_id_t          key_q, key_d;
    logic             valid_q, valid_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q;
    key_id_t          id_w;
`ifdef PS2_REPEAT_EN
    logic             rep_q, rep_d;
`endif

    assign id_w.ext  = ext_pend_q;
    assign id_w.code = code_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (kbd.kbd_ready) state_d = POP;
            POP:     state_d = SETTLE;
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nextdata_n_d = 1'b1;
        code_d       = code_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        key_d        = key_q;
        valid_d      = valid_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        cnt_d        = cnt_q;
`ifdef PS2_REPEAT_EN
        rep_d        = 1'b0;
`endif
        if (state_q == IDLE && kbd.kbd_ready) begin
            code_d       = kbd.kbd_data;
            nextdata_n_d = 1'b0;
        end
        if (state_q == POP) begin
            case (code_q)
                PS2_BRK:   brk_pend_d = 1'b1;
                PS2_EXT:   ext_pend_d = 1'b1;
                PS2_PAUSE: begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
                default: begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (!brk_pend_q) begin
                        // a make of the key already held is typematic repeat
                        if (valid_q && key_q == id_w) begin
`ifdef PS2_REPEAT_EN
                            rep_d = 1'b1;
`endif
                        end else begin
                            key_d   = id_w;
                            valid_d = 1'b1;
                            press_d = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else if (valid_q && key_q == id_w) begin
                        key_d     = '0;
                        valid_d   = 1'b0;
                        release_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nextdata_n_q <= 1'b1;
            code_q       <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            key_q        <= '0;
            valid_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            nextdata_n_q <= nextdata_n_d;
            code_q       <= code_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            key_q        <= key_d;
            valid_q      <= valid_d;
            press_q      <= press_d;
            release_q    <= release_d;
            cnt_q        <= cnt_d;
        end
    end

    // overflow set wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst)                   ovf_q <= 1'b0;
        else if (kbd.kbd_overflow) ovf_q <= 1'b1;
        else if (ovf_clr)          ovf_q <= 1'b0;
    end

`ifdef PS2_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) rep_q <= 1'b0;
        else     rep_q <= rep_d;
    end
    assign repeat_pulse = rep_q;
`endif

    assign kbd.kbd_nextdata_n = nextdata_n_q;
    assign key_code           = key_q.code;
    assign key_ext            = key_q.ext;
    assign key_valid          = valid_q;
    assign press_pulse        = press_q;
    assign release_pulse      = release_q;
    assign press_count        = cnt_q;
    assign ovf_flag           = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a FIFO model feeds bytes, a monitor checks each event.
module tb_ps2_key_ctrl;

    localparam int CNT_W = 8;

    typedef enum int {EV_NONE, EV_PRESS, EV_REL, EV_REP} ev_e;
    typedef struct {
        ev_e        k;
        logic [7:0] code;
        logic       ext;
        logic       vld;
        logic [7:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ovf_clr = 1'b0;
    logic [7:0]       key_code;
    logic             key_ext, key_valid, press_pulse, release_pulse, ovf_flag;
    logic [CNT_W-1:0] press_count;
    logic             rep_pulse;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fifo_q[$];
    exp_t        exp_q[$];

    ps2_key_ctrl_if kif();

    ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .kbd          (kif.slave),
        .ovf_clr      (ovf_clr),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_valid    (key_valid),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_count  (press_count),
        .ovf_flag     (ovf_flag)
`ifdef PS2_REPEAT_EN
        ,
        .repeat_pulse (rep_pulse)
`endif
    );

`ifndef PS2_REPEAT_EN
    assign rep_pulse = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO model: pops while nextdata_n is low, then presents the new head
    initial begin
        kif.kbd_data  = 8'h00;
        kif.kbd_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (kif.kbd_nextdata_n === 1'b0 && fifo_q.size() != 0) void'(fifo_q.pop_front());
            #1;
            kif.kbd_ready = (fifo_q.size() != 0);
            kif.kbd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    // monitor: every event pulse must match the head of the scoreboard
    initial begin
        exp_t e;
        ev_e  act;
        forever begin
            @(negedge clk);
            if (!rst && (press_pulse || release_pulse || rep_pulse)) begin
                check("pulse_exclusive", {31'd0, press_pulse & release_pulse}, 32'd0);
                act = press_pulse ? EV_PRESS : (release_pulse ? EV_REL : EV_REP);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d code %0h, expected none", act, key_code);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind", act, e.k);
                    check("ev_code", key_code, e.code);
                    check("ev_ext", key_ext, e.ext);
                    check("ev_valid", key_valid, e.vld);
                    check("ev_count", press_count, e.cnt);
                end
            end
        end
    end

    task automatic expect_ev(input ev_e k, input logic [7:0] c, input logic x, input int n);
        exp_t e;
        if (k != EV_NONE) begin
            e.k = k; e.code = c; e.ext = x; e.vld = (k != EV_REL); e.cnt = n[7:0];
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (fifo_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (fifo_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bytes left, expected 0", fifo_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input ev_e k, input logic [7:0] c, input logic x, input int n);
        expect_ev(k, c, x, n);
        fifo_q.push_back(b);
        drain();
    endtask

    localparam ev_e REP_EV =
`ifdef PS2_REPEAT_EN
        EV_REP;
`else
        EV_NONE;
`endif

    initial begin
        int nlow, last, t;
        logic [7:0] c;
        logic x;
        kif.kbd_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nextdata_n", kif.kbd_nextdata_n, 1);
        check("rst_key_code", key_code, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_ext", key_ext, 0);
        check("rst_count", press_count, 0);
        check("rst_ovf", ovf_flag, 0);
        check("rst_pulses", {press_pulse, release_pulse}, 0);
        rst = 1'b0;
        @(negedge clk);

        // make then break
        send(8'h1C, EV_PRESS, 8'h1C, 0, 1);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h1C, EV_REL,   8'h00, 0, 1);
        // typematic
        send(8'h1C, EV_PRESS, 8'h1C, 0, 2);
        send(8'h1C, REP_EV,   8'h1C, 0, 2);
        send(8'h1C, REP_EV,   8'h1C, 0, 2);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h1C, EV_REL,   8'h00, 0, 2);
        // extended key; plain break of same code must not release it
        send(8'hE0, EV_NONE,  8'h00, 0, 0);
        send(8'h75, EV_PRESS, 8'h75, 1, 3);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h75, EV_NONE,  8'h00, 0, 0);
        check("ext_still_held", {key_valid, key_ext, key_code}, {2'b11, 8'h75});
        send(8'hE0, EV_NONE,  8'h00, 0, 0);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h75, EV_REL,   8'h00, 0, 3);
        // replacement; break of old key ignored
        send(8'h1C, EV_PRESS, 8'h1C, 0, 4);
        send(8'h32, EV_PRESS, 8'h32, 0, 5);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h1C, EV_NONE,  8'h00, 0, 0);
        check("replace_held", {key_valid, key_code}, {1'b1, 8'h32});
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h32, EV_REL,   8'h00, 0, 5);
        // E1 drops pending E0; F0 E0 order; F0 F0
        send(8'hE0, EV_NONE,  8'h00, 0, 0);
        send(8'hE1, EV_NONE,  8'h00, 0, 0);
        send(8'h1C, EV_PRESS, 8'h1C, 0, 6);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'hE0, EV_NONE,  8'h00, 0, 0);
        send(8'h1C, EV_NONE,  8'h00, 0, 0);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h1C, EV_REL,   8'h00, 0, 6);

        // latency: byte visible before edge of cycle t -> pulse in t+2 only
        expect_ev(EV_PRESS, 8'h4D, 0, 7);
        fifo_q.push_back(8'h4D);
        @(negedge clk); check("lat_t1", press_pulse, 0);
        @(negedge clk); check("lat_t2", press_pulse, 1);
        @(negedge clk); check("lat_t3", press_pulse, 0);
        drain();
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h4D, EV_REL,   8'h00, 0, 7);

        // back-to-back bytes: one pop strobe every 3 cycles
        expect_ev(EV_PRESS, 8'h1C, 0, 8);
        expect_ev(EV_REL,   8'h00, 0, 8);
        expect_ev(EV_PRESS, 8'h32, 0, 9);
        expect_ev(EV_REL,   8'h00, 0, 9);
        fifo_q.push_back(8'h1C); fifo_q.push_back(8'hF0); fifo_q.push_back(8'h1C);
        fifo_q.push_back(8'h32); fifo_q.push_back(8'hF0); fifo_q.push_back(8'h32);
        nlow = 0;
        last = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (kif.kbd_nextdata_n === 1'b0) begin
                if (nlow > 0) check("pop_gap", i - last, 3);
                last = i;
                nlow++;
            end
        end
        check("pop_total", nlow, 6);
        drain();

        // overflow flag: set beats clear, then clear alone
        kif.kbd_overflow = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        kif.kbd_overflow = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_wins", ovf_flag, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf_flag, 0);
        kif.kbd_overflow = 1'b1;
        @(negedge clk);
        kif.kbd_overflow = 1'b0;
        check("ovf_set", ovf_flag, 1);

        // reset while in POP
        send(8'h1C, EV_PRESS, 8'h1C, 0, 10);
        fifo_q.push_back(8'hF0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (kif.kbd_nextdata_n !== 1'b0 && t < 20);
        check("pop_seen", kif.kbd_nextdata_n, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rstpop_nextdata_n", kif.kbd_nextdata_n, 1);
        check("rstpop_key", {key_valid, key_ext, key_code}, 0);
        check("rstpop_count", press_count, 0);
        check("rstpop_ovf", ovf_flag, 0);
        check("rstpop_pulses", {press_pulse, release_pulse}, 0);
        rst = 1'b0;
        fifo_q.delete();
        repeat (2) @(negedge clk);
        send(8'h1C, EV_PRESS, 8'h1C, 0, 1);
        send(8'hF0, EV_NONE,  8'h00, 0, 0);
        send(8'h1C, EV_REL,   8'h00, 0, 1);

        // 256 distinct make/break pairs wrap the counter
        for (int i = 0; i < 256; i++) begin
            x = (i >= 200);
            c = x ? 8'(i - 199) : 8'(i + 1);
            if (x) send(8'hE0, EV_NONE, 8'h00, 0, 0);
            send(c, EV_PRESS, c, x, (2 + i) % 256);
            if (x) send(8'hE0, EV_NONE, 8'h00, 0, 0);
            send(8'hF0, EV_NONE, 8'h00, 0, 0);
            send(c, EV_REL, 8'h00, 0, (2 + i) % 256);
        end
        check("wrap_count", press_count, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequencer placed between the ps2_keyboard FIFO receiver and the scan-to-ASCII lookup.
- Drains the FIFO through its ready/nextdata_n handshake, one byte at a time.
- Interprets E0 (extended) and F0 (break) prefixes and tracks the currently held key.
- Emits one-cycle press/release events and a press counter for the display path.

Parameters:
- CNT_W, 8, width of press_count (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- kbd_data  in  8  FIFO head byte from ps2_keyboard.data.
- kbd_ready  in  1  FIFO non-empty (ps2_keyboard.ready).
- kbd_overflow  in  1  FIFO overflow (ps2_keyboard.overflow).
- kbd_nextdata_n  out  1  active-low pop strobe to ps2_keyboard.nextdata_n (registered).
- ovf_clr  in  1  clears ovf_flag.
- key_code  out  8  scan code of the held key; 0 when none.
- key_ext  out  1  held key is extended (E0-prefixed).
- key_valid  out  1  a key is currently held.
- press_pulse  out  1  one cycle: new make accepted.
- release_pulse  out  1  one cycle: held key released.
- press_count  out  CNT_W  accepted presses since reset.
- ovf_flag  out  1  sticky FIFO overflow seen.

Behaviour:
- Reset values:
  - state=IDLE; kbd_nextdata_n=1.
  - key_code=0, key_ext=0, key_valid=0, press_pulse=0, release_pulse=0, press_count=0, ovf_flag=0.
  - Internal ext_pend=0, brk_pend=0, code_r=0.
- FSM, one byte per 3 cycles minimum:
  - IDLE: if kbd_ready, latch code_r<=kbd_data, kbd_nextdata_n<=0, go to POP. Otherwise stay.
  - POP: kbd_nextdata_n is 0 for exactly this cycle; the FIFO pops at the end of it. Decode code_r at this edge, set kbd_nextdata_n<=1, go to SETTLE.
  - SETTLE: one dead cycle so FIFO ready/data reflect the pop; go to IDLE.
- Latency: byte present with kbd_ready in cycle t → event pulse high in cycle t+2 only.
- Decode in POP:
  - code_r==F0: brk_pend<=1. No event.
  - code_r==E0: ext_pend<=1. No event.
  - code_r==E1: byte dropped; both pending flags cleared.
  - Any other byte: it is a key byte, with identity {ext_pend, code_r}. Both pending flags are cleared afterwards.
- Make (brk_pend=0):
  - If key_valid and identity equals the held key, this is typematic repeat: ignored, no count.
  - Otherwise key_code/key_ext<=identity, key_valid<=1, press_pulse, press_count+1.
  - A different key pressed while one is held replaces it.
- Break (brk_pend=1):
  - If identity equals the held key: key_valid<=0, key_code<=0, key_ext<=0, release_pulse.
  - Otherwise ignored, with no state change.
- Repeated prefixes (F0 F0, E0 E0) leave the flag set; order E0 F0 and F0 E0 are both accepted.
- press_count wraps from 2^CNT_W-1 to 0.
- ovf_flag:
  - Set on any cycle with kbd_overflow=1.
  - Cleared by ovf_clr or rst.
  - Set wins over clear in the same cycle.
- press_pulse and release_pulse are never high together.
- Reset asserted in POP: the pop may be aborted; the byte is re-read from IDLE after reset and decoded with cleared prefixes.
- kbd_ready falling during POP/SETTLE has no effect; kbd_ready is sampled only in IDLE.

Optional Feature:
- PS2_REPEAT_EN defined:
  - Adds output repeat_pulse (1 bit), a one-cycle pulse in the same slot as press_pulse when a typematic make of the held key arrives.
  - press_count is unchanged on repeat.
- Undefined: no repeat_pulse port; repeats are silently ignored.

Decomposition:
- ps2_pkg holds:
  - Constants PS2_BRK=8'hF0, PS2_EXT=8'hE0, PS2_PAUSE=8'hE1.
  - Enum ctrl_state_t {IDLE, POP, SETTLE}.
  - Struct key_id_t {ext, code}.
- No sub-module is needed; decode is inline in the FSM. ps2_keyboard and the ASCII lookup are instantiated beside this block by the top level.

Test Plan:
- Byte 1C then F0 1C:
  - press_pulse for 1 cycle at t+2, key_code=1C, key_valid=1, press_count=1.
  - Then release_pulse, key_valid=0, key_code=0.
- 1C 1C 1C (typematic):
  - Exactly one press_pulse; press_count=1.
  - With PS2_REPEAT_EN, two repeat_pulse.
- E0 75 then E0 F0 75: key_ext=1, key_code=75, press then release. A plain F0 75 in between does not release it.
- 1C then 32 then F0 1C:
  - 32 replaces 1C, press_count=2.
  - F0 1C gives no release_pulse; key_code stays 32.
- Back-to-back bytes with kbd_ready held high:
  - kbd_nextdata_n is low exactly 1 cycle in every 3.
  - No byte is skipped or popped twice.
- Stimuli:
  - 256 distinct make/break pairs → press_count wraps to 0.
  - kbd_overflow pulse with simultaneous ovf_clr → ovf_flag=1; a later ovf_clr alone clears it.
  - rst during POP → all outputs return to reset values next cycle.
